// File: rtl/prof_pkg.sv
// Shared state encoding and default sizing for the PC loop profiler.
package prof_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COUNT,
        FULL
    } prof_state_e;

    localparam int PROF_DEPTH = 20;
    localparam int PROF_CNT_W = 32;
    localparam int PROF_IDX_W = 5;

endpackage

// File: rtl/prof_rec_buf.sv
// Interval record buffer: DEPTH x CNT_W registers, one write port and one
// registered read port with write-first bypass and an out-of-range limit.
module prof_rec_buf
    import prof_pkg::*;
#(
    parameter int DEPTH = PROF_DEPTH,
    parameter int CNT_W = PROF_CNT_W,
    parameter int IDX_W = PROF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [IDX_W:0]   rd_lim,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid
);

    logic [CNT_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] rd_data_q;
    logic [CNT_W-1:0] rd_data_d;
    logic             rd_valid_q;

    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_idx) < DEPTH)) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // A write landing on the read index wins, even though that index is
    // still beyond the record count this cycle.
    always_comb begin
        rd_data_d = '0;
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_data_d = wr_data;
        end else if ({1'b0, rd_idx} < rd_lim) begin
            rd_data_d = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/pc_loop_profiler.sv
// Per-iteration loop cycle profiler watching the core PC for a trigger address.
// Define PROF_SAT_EN to make the interval counter saturate instead of wrapping.
module pc_loop_profiler
    import prof_pkg::*;
#(
    parameter int DEPTH = PROF_DEPTH,
    parameter int CNT_W = PROF_CNT_W,
    parameter int IDX_W = PROF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic             en,
    input  logic [31:0]      trig_addr,
    input  logic             clr,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic [IDX_W:0]   rec_count,
    output logic             full,
    output logic             ovf
);

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

    prof_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W:0]   rec_count_q;
    logic [IDX_W:0]   rec_count_d;
    logic             full_q;
    logic             ovf_q;
    logic             hit;
    logic             wr_en;

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c);
`ifdef PROF_SAT_EN
        return (&c) ? c : c + CNT_W'(1);
`else
        return c + CNT_W'(1);
`endif
    endfunction

    assign hit         = (pc == trig_addr);
    assign rec_count_d = rec_count_q + (IDX_W + 1)'(1);
    assign wr_en       = !rst && !clr && en && (state_q == COUNT) && hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rec_count_q <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (clr) begin
            cnt_q       <= '0;
            rec_count_q <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            state_q     <= en ? ARMED : IDLE;
        end else if (!en) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= ARMED;
                end
                ARMED: begin
                    // Re-enabled with the buffer already full: no room to count.
                    if (full_q) begin
                        state_q <= FULL;
                        if (hit) begin
                            ovf_q <= 1'b1;
                        end
                    end else if (hit) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (hit) begin
                        rec_count_q <= rec_count_d;
                        cnt_q       <= CNT_W'(1);
                        if (rec_count_d == DEPTH_C) begin
                            full_q  <= 1'b1;
                            state_q <= FULL;
                        end
                    end else begin
                        cnt_q <= cnt_next(cnt_q);
                    end
                end
                FULL: begin
                    if (hit) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    prof_rec_buf #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_idx   (rec_count_q[IDX_W-1:0]),
        .wr_data  (cnt_q),
        .rd_en    (rd_en),
        .rd_idx   (rd_idx),
        .rd_lim   (rec_count_q),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    assign rec_count = rec_count_q;
    assign full      = full_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/pc_loop_profiler.md
Name: pc_loop_profiler

Overview:
- Hardware cycle profiler that sits directly downstream of riscv_core and consumes its program counter every clock.
- Measures the number of cycles between consecutive arrivals of the PC at a programmable trigger address, i.e. the per-iteration cycle count of a loop.
- Stores each measured interval in an internal record buffer.
- Replaces bench-side counting logic, so loop timing is available to synthesisable debug logic and to the verification bench through one read port.

Parameters:
- DEPTH, 20, number of interval records stored.
- CNT_W, 32, width of interval counter and record data.
- IDX_W, 5, width of record index; must satisfy 2^IDX_W >= DEPTH.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pc  input  32  current program counter from riscv_core.
- en  input  1  profiling enable; low forces IDLE.
- trig_addr  input  32  PC value that marks one loop iteration.
- clr  input  1  synchronous clear of records and counter.
- rd_en  input  1  read request.
- rd_idx  input  IDX_W  record index to read.
- rd_data  output  CNT_W  record value, registered.
- rd_valid  output  1  rd_data valid, one cycle after rd_en.
- rec_count  output  IDX_W+1  number of records written (0..DEPTH).
- full  output  1  high when rec_count == DEPTH.
- ovf  output  1  sticky: a hit occurred while full.

Behaviour:
- Reset: state IDLE; counter 0; rec_count 0; full 0; ovf 0; rd_data 0; rd_valid 0. Buffer contents are not cleared.
- hit = (pc == trig_addr), evaluated every cycle; riscv_core is single-cycle, so every cycle carries a valid PC.
- IDLE: en=1 -> ARMED. No counting.
- ARMED: first hit sets counter to 1, records nothing, -> COUNT.
- COUNT, on hit: write the counter value to buf[rec_count], rec_count+1, counter reloads to 1.
- COUNT, no hit: counter+1.
- Interval semantics: hits at cycles 10 and 14 record 4. Hits on back-to-back cycles record 1.
- COUNT: the write that makes rec_count == DEPTH asserts full and moves to FULL.
- FULL: counter frozen; any hit sets ovf. Records are never overwritten and there is no wrap-around.
- en low in any state -> IDLE next cycle. Counter, records, rec_count, full and ovf are held. Re-enabling goes to ARMED, so the first hit after re-enable is not recorded.
- clr (priority below rst, above all else): counter 0, rec_count 0, full 0, ovf 0. Next state is ARMED if en, else IDLE. A hit in the clr cycle is ignored.
- Read: rd_en at cycle N gives rd_data = buf[rd_idx] and rd_valid=1 at N+1; rd_valid=0 otherwise.
- Out of range read: rd_idx >= rec_count returns 0.
- Same-cycle read and write of the same index returns the new value (write-first bypass).
- Counter arithmetic is unsigned CNT_W. With the optional feature absent, the counter wraps modulo 2^CNT_W.

Optional Feature:
- Macro PROF_SAT_EN.
- Defined: counter saturates at all-ones and the saturated value is recorded as is.
- Absent: counter wraps modulo 2^CNT_W.

Decomposition:
- Shared package prof_pkg holds: state enum (IDLE, ARMED, COUNT, FULL) and the default DEPTH/CNT_W constants.
- One sub-module, prof_rec_buf: DEPTH x CNT_W register buffer with one write port and one registered read port with bypass.
- The FSM and counter stay in the top module.

Test Plan:
- en=1, trig_addr=0x10, PC hits at cycles 5, 9, 13, 20 -> records {4, 4, 7}, rec_count=3.
- pc held at 0x10 for 5 cycles -> records {1, 1, 1, 1}.
- 22 hits spaced 3 cycles apart, DEPTH=20 -> 20 records of 3, full=1 at the 21st hit, ovf=1 at the 22nd hit, rec_count=20.
- Mid-run: en dropped for 6 cycles, then raised -> rec_count unchanged; the next hit re-arms only; the following interval excludes the gap.
- clr pulsed in the same cycle as a hit -> rec_count=0, no record written, state ARMED; the next hit records nothing.
- Reads: rd_en with rd_idx=1 -> rd_valid=1 and rd_data=4 next cycle; rd_idx=25 -> rd_data=0.
- With PROF_SAT_EN and CNT_W=4: 20-cycle gap records 15. Without the macro, a 20-cycle gap records 4.
